// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: payload + valid, stall/bubble/flush handling, perf counters.
// Optional payload parity checking is enabled by defining PIPE_STAGE_REG_PARITY_EN.
module pipe_stage_reg #(
    parameter int unsigned DATA_W    = 76,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned STAGE_IDX = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic               par_err
);

    generate
        if (STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
            $error("pipe_stage_reg: STAGE_IDX %0d out of range 0..%0d", STAGE_IDX, STALL_W - 2);
        end
    endgenerate

    typedef enum logic [1:0] {
        OP_ADVANCE,
        OP_HOLD,
        OP_BUBBLE,
        OP_FLUSH
    } op_e;

    logic              up, dn;
    op_e               op;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic [CNT_W-1:0]  hold_q,   hold_d;

    assign up = stall[STAGE_IDX];
    assign dn = stall[STAGE_IDX+1];

    // Flush beats everything; a downstream stall freezes us whatever upstream does.
    always_comb begin
        op = OP_ADVANCE;
        if (flush)         op = OP_FLUSH;
        else if (up && !dn) op = OP_BUBBLE;
        else if (dn)       op = OP_HOLD;
    end

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        bubble_d = bubble_q;
        hold_d   = '0;
        case (op)
            OP_FLUSH: begin
                valid_d = 1'b0;
                data_d  = NOP_VALUE;
            end
            OP_BUBBLE: begin
                valid_d  = 1'b0;
                data_d   = NOP_VALUE;
                bubble_d = (&bubble_q) ? bubble_q : bubble_q + 1'b1;
            end
            OP_HOLD: begin
                hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;
            end
            default: begin
                valid_d = in_valid;
                data_d  = in_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= NOP_VALUE;
            bubble_q <= '0;
            hold_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            bubble_q <= bubble_d;
            hold_q   <= hold_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign bubble_cnt = bubble_q;
    assign hold_cnt   = hold_q;

`ifdef PIPE_STAGE_REG_PARITY_EN
    logic par_q, par_d;
    logic par_err_q, par_err_d;

    always_comb begin
        par_d = par_q;
        case (op)
            OP_ADVANCE: par_d = ^in_data;
            OP_HOLD:    par_d = par_q;
            default:    par_d = ^NOP_VALUE;
        endcase
        // Checked against the driven output so corruption on the bus is caught too.
        par_err_d = (^out_data) != par_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q     <= ^NOP_VALUE;
            par_err_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, advance, bubble, hold, flush, saturation, parity.
module tb_pipe_stage_reg;
    localparam int DW = 76;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid, out_valid2;
    logic [DW-1:0] out_data, out_data2;
    logic [15:0]   bubble_cnt, hold_cnt;
    logic [1:0]    bubble_cnt2, hold_cnt2;
    logic          par_err, par_err2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .STAGE_IDX(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt), .par_err(par_err)
    );

    pipe_stage_reg #(.DATA_W(DW), .STAGE_IDX(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid2), .out_data(out_data2),
        .bubble_cnt(bubble_cnt2), .hold_cnt(hold_cnt2), .par_err(par_err2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [15:0] b, input logic [15:0] h);
        chk({tag, ".valid"}, out_valid, v);
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".bubble"}, bubble_cnt, b);
        chk({tag, ".hold"}, hold_cnt, h);
        chk({tag, ".par_err"}, par_err, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        step(); step();
        chk_out("reset", 1'b0, '0, 16'd0, 16'd0);
        rst_n = 1'b1;

        // advance
        in_valid = 1'b1; in_data = 76'hABCD;
        step();
        chk_out("adv", 1'b1, 76'hABCD, 16'd0, 16'd0);

        // bubble x3: up=stall[2]=1, dn=stall[3]=0
        stall = 6'b000111; in_data = 76'hDEAD;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_out($sformatf("bubble%0d", i), 1'b0, '0, 16'(i), 16'd0);
        end
        chk("bubble.cnt2", bubble_cnt2, 2'd3);

        // load 55 then hold x4
        stall = '0; in_valid = 1'b1; in_data = 76'h55;
        step();
        chk_out("load55", 1'b1, 76'h55, 16'd3, 16'd0);
        stall = 6'b001111; in_data = 76'h99;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_out($sformatf("hold%0d", i), 1'b1, 76'h55, 16'd3, 16'(i));
        end

        // release loads the waiting word
        stall = '0; in_data = 76'h77;
        step();
        chk_out("release", 1'b1, 76'h77, 16'd3, 16'd0);

        // hold twice, then flush while stall still asserted
        stall = 6'b001111; in_data = 76'h88;
        step(); step();
        chk_out("prehold", 1'b1, 76'h77, 16'd3, 16'd2);
        flush = 1'b1;
        step();
        chk_out("flush", 1'b0, '0, 16'd3, 16'd0);
        flush = 1'b0;

        // two more bubbles: main counts to 5, 2-bit counter saturates at 3
        stall = 6'b000111;
        step(); step();
        chk_out("bubble5", 1'b0, '0, 16'd5, 16'd0);
        chk("sat.cnt2", bubble_cnt2, 2'd3);
        chk("sat.valid2", out_valid2, 1'b0);

        // in_valid=0 on advance still loads the payload
        stall = '0; in_valid = 1'b0; in_data = 76'h1234;
        step();
        chk_out("inval", 1'b0, 76'h1234, 16'd5, 16'd0);

`ifdef PIPE_STAGE_REG_PARITY_EN
        // corrupt the held payload for one edge
        in_valid = 1'b1; in_data = 76'h55;
        step();
        stall = 6'b001111;
        step();
        force dut.out_data = 76'h54;
        step();
        chk("par.flag", par_err, 1'b1);
        release dut.out_data;
        step();
        chk("par.clear", par_err, 1'b0);
        stall = '0;
`endif

        // reset mid-hold, checked between edges
        in_valid = 1'b1; in_data = 76'h1234;
        step();
        stall = 6'b001111;
        step(); step();
        chk("mid.hold", hold_cnt, 16'd2);
        chk("mid.valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, '0, 16'd0, 16'd0);
        chk("async_rst.cnt2", bubble_cnt2, 2'd0);
        step();
        rst_n = 1'b1; stall = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
